// File: rtl/tilt_quantizer.sv
// ============================================================================
// tilt_quantizer: converts signed accelerometer X/Y samples into a 2-bit tilt
// code using dominant-axis detection, hysteresis and a stability filter.
// Optional zero-offset calibration is built when TILT_CAL_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tilt_quantizer #(
  parameter int DATA_W     = 12,
  parameter int THRESH     = 256,
  parameter int HYST       = 64,
  parameter int STABLE_CNT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] accel_x,
  input  logic signed [DATA_W-1:0] accel_y,
  input  logic                     cal_capture,
  output logic [1:0]               tilt_out,
  output logic                     tilt_active,
  output logic                     tilt_change
);

  localparam int MAG_W = DATA_W - 1;
  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [MAG_W-1:0]  MAG_MAX  = '1;
  localparam logic [MAG_W-1:0]  THRESH_M = MAG_W'(THRESH);
  localparam logic [MAG_W-1:0]  LOW_M    = MAG_W'(THRESH - HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT);
  localparam logic [DATA_W-1:0] S_MIN    = {1'b1, {MAG_W{1'b0}}};

  // Most negative value has no positive twin, so it clamps to the max magnitude.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [DATA_W-1:0] v);
    if (v == S_MIN)  return MAG_MAX;
    else if (v[DATA_W-1]) return MAG_W'(-v);
    else             return v[MAG_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] w_cx, w_cy;
  logic                     w_accept;

`ifdef TILT_CAL_EN
  function automatic logic [DATA_W-1:0] sub_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] o);
    logic [DATA_W:0] d;
    d = {a[DATA_W-1], a} - {o[DATA_W-1], o};
    if (d[DATA_W] != d[DATA_W-1]) return d[DATA_W] ? S_MIN : ~S_MIN;
    else                          return d[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] off_x_q, off_y_q;
  logic              cal_pend_q;
  logic              w_capture;

  assign w_capture = sample_valid & (cal_capture | cal_pend_q);
  assign w_accept  = sample_valid & ~w_capture;
  assign w_cx      = sub_sat(accel_x, off_x_q);
  assign w_cy      = sub_sat(accel_y, off_y_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_x_q    <= '0;
      off_y_q    <= '0;
      cal_pend_q <= 1'b0;
    end else if (w_capture) begin
      off_x_q    <= accel_x;
      off_y_q    <= accel_y;
      cal_pend_q <= 1'b0;
    end else if (cal_capture) begin
      cal_pend_q <= 1'b1;
    end
  end
`else
  logic unused_cal;
  assign unused_cal = cal_capture;
  assign w_accept   = sample_valid;
  assign w_cx       = accel_x;
  assign w_cy       = accel_y;
`endif

  // Stage 1: magnitudes and signs
  logic             s1_vld_q, s1_nx_q, s1_ny_q;
  logic [MAG_W-1:0] s1_ax_q, s1_ay_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_nx_q  <= 1'b0;
      s1_ny_q  <= 1'b0;
      s1_ax_q  <= '0;
      s1_ay_q  <= '0;
    end else begin
      s1_vld_q <= w_accept;
      if (w_accept) begin
        s1_nx_q <= w_cx[DATA_W-1];
        s1_ny_q <= w_cy[DATA_W-1];
        s1_ax_q <= abs_sat(w_cx);
        s1_ay_q <= abs_sat(w_cy);
      end
    end
  end

  // Stage 2: dominant axis and candidate code
  logic             w_xdom;
  logic [MAG_W-1:0] w_mag;
  logic             s2_vld_q, s2_hit_q, s2_nx_q, s2_ny_q;
  logic [1:0]       s2_code_q;
  logic [MAG_W-1:0] s2_ax_q, s2_ay_q;

  assign w_xdom = (s1_ax_q >= s1_ay_q);
  assign w_mag  = w_xdom ? s1_ax_q : s1_ay_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q  <= 1'b0;
      s2_hit_q  <= 1'b0;
      s2_code_q <= 2'b00;
      s2_nx_q   <= 1'b0;
      s2_ny_q   <= 1'b0;
      s2_ax_q   <= '0;
      s2_ay_q   <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_hit_q  <= (w_mag >= THRESH_M);
        s2_code_q <= w_xdom ? {1'b0, ~s1_nx_q} : {1'b1, ~s1_ny_q};
        s2_nx_q   <= s1_nx_q;
        s2_ny_q   <= s1_ny_q;
        s2_ax_q   <= s1_ax_q;
        s2_ay_q   <= s1_ay_q;
      end
    end
  end

  // Stage 3: stability counter, commit and hysteresis
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_hit_q;
  logic [1:0]       prev_code_q;
  logic [1:0]       tilt_out_q;
  logic             tilt_active_q, tilt_change_q;
  logic             w_commit, w_drop, w_com_neg;
  logic [MAG_W-1:0] w_com_mag;

  always_comb begin
    cnt_d = cnt_q;
    if (!s2_hit_q)
      cnt_d = '0;
    else if (prev_hit_q && (s2_code_q == prev_code_q))
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    else
      cnt_d = CNT_W'(1);
  end

  assign w_commit  = s2_hit_q && (cnt_d == CNT_MAX);
  assign w_com_mag = tilt_out_q[1] ? s2_ay_q : s2_ax_q;
  assign w_com_neg = tilt_out_q[1] ? s2_ny_q : s2_nx_q;
  // Code bit 0 set means positive direction, so a matching negative flag is a flip.
  assign w_drop    = (w_com_mag < LOW_M) || (w_com_neg == tilt_out_q[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      prev_hit_q    <= 1'b0;
      prev_code_q   <= 2'b00;
      tilt_out_q    <= 2'b00;
      tilt_active_q <= 1'b0;
      tilt_change_q <= 1'b0;
    end else begin
      tilt_change_q <= 1'b0;
      if (s2_vld_q) begin
        cnt_q       <= cnt_d;
        prev_hit_q  <= s2_hit_q;
        prev_code_q <= s2_code_q;
        if (w_commit) begin
          tilt_out_q    <= s2_code_q;
          tilt_active_q <= 1'b1;
          tilt_change_q <= (s2_code_q != tilt_out_q);
        end else if (tilt_active_q && w_drop) begin
          tilt_active_q <= 1'b0;
        end
      end
    end
  end

  assign tilt_out    = tilt_out_q;
  assign tilt_active = tilt_active_q;
  assign tilt_change = tilt_change_q;

endmodule

`default_nettype wire

// File: tb/tb_tilt_quantizer.sv
// ============================================================================
// tb_tilt_quantizer: directed self-checking bench for tilt_quantizer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tilt_quantizer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sample_valid = 1'b0;
  logic signed [11:0] accel_x = '0;
  logic signed [11:0] accel_y = '0;
  logic              cal_capture = 1'b0;
  logic [1:0]        tilt_out;
  logic              tilt_active;
  logic              tilt_change;

  int checks = 0;
  int failures = 0;
  int n_chg = 0;

  tilt_quantizer #(.DATA_W(12), .THRESH(256), .HYST(64), .STABLE_CNT(4)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .accel_x(accel_x), .accel_y(accel_y), .cal_capture(cal_capture),
    .tilt_out(tilt_out), .tilt_active(tilt_active), .tilt_change(tilt_change)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tilt_change === 1'b1) n_chg++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input logic cal);
    @(negedge clk);
    sample_valid = 1'b1;
    accel_x = x[11:0];
    accel_y = y[11:0];
    cal_capture = cal;
    @(negedge clk);
    sample_valid = 1'b0;
    cal_capture = 1'b0;
  endtask

  task automatic send_n(input int x, input int y, input int n);
    repeat (n) send(x, y, 1'b0);
  endtask

  task automatic settle;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out", tilt_out, 2'b00);
    check("rst_active", tilt_active, 1'b0);
    check("rst_change", tilt_change, 1'b0);
    reset = 1'b0;

    // Commit +X with exact two-edge latency
    send_n(300, 0, 4);
    @(posedge clk); #1;
    check("lat_e1_change", tilt_change, 1'b0);
    @(posedge clk); #1;
    check("lat_e2_change", tilt_change, 1'b1);
    check("lat_e2_out", tilt_out, 2'b01);
    check("lat_e2_active", tilt_active, 1'b1);
    @(posedge clk); #1;
    check("lat_e3_change", tilt_change, 1'b0);

    // Hysteresis on +X
    send(220, 0, 1'b0); settle;
    check("hyst_keep", tilt_active, 1'b1);
    send(180, 0, 1'b0); settle;
    check("hyst_clear", tilt_active, 1'b0);
    check("hyst_out", tilt_out, 2'b01);
    check("hyst_nochg", n_chg, 1);
    send_n(300, 0, 4); settle;
    check("recommit_active", tilt_active, 1'b1);
    check("recommit_nochg", n_chg, 1);

    // Broken run clears the counter
    send_n(0, -400, 3);
    send(0, -100, 1'b0);
    send(0, -400, 1'b0); settle;
    check("clear_out", tilt_out, 2'b01);
    check("clear_nochg", n_chg, 1);

    // Saturated minimum and tie handling
    send_n(-2048, 0, 4); settle;
    check("sat_out", tilt_out, 2'b00);
    check("sat_chg", n_chg, 2);
    send_n(300, 300, 4); settle;
    check("tie_out", tilt_out, 2'b01);

    // Back-to-back strobes every cycle
    @(negedge clk);
    sample_valid = 1'b1; accel_x = '0; accel_y = 12'sd400;
    repeat (4) @(negedge clk);
    sample_valid = 1'b0;
    settle;
    check("b2b_out", tilt_out, 2'b11);
    check("b2b_chg", n_chg, 4);

    // Asynchronous reset mid-stream discards the partial count
    send_n(-300, 0, 3);
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_out", tilt_out, 2'b00);
    check("mid_rst_active", tilt_active, 1'b0);
    check("mid_rst_change", tilt_change, 1'b0);
    reset = 1'b0;
    send(-300, 0, 1'b0); settle;
    check("mid_rst_lost", tilt_active, 1'b0);

    // Calibration capture
    send(200, 0, 1'b1);
`ifdef TILT_CAL_EN
    send_n(300, 0, 4); settle;
    check("cal_nocommit", tilt_active, 1'b0);
    send_n(480, 0, 4); settle;
    check("cal_commit_out", tilt_out, 2'b01);
    check("cal_commit_active", tilt_active, 1'b1);
`else
    send_n(300, 0, 4); settle;
    check("nocal_out", tilt_out, 2'b01);
    check("nocal_active", tilt_active, 1'b1);
`endif
    check("final_chg", n_chg, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
